bus_cycle_initiator: RTL and testbench

Minimum-mode 8088 bus master that turns a single-transfer request into a standard T1-T2-T3-(Tw)-T4 bus cycle. It drives the multiplexed A/AD pins, ALE, IOM, RD/WR strobes, DTR and DEN, so the existing address latch, transceiver, chip-select logic and memory/IO peripherals respond to it unchanged. It serves as a lightweight, directly controllable initiator for DMA-style transfers and for peripheral bring-up without the full processor model.

---
 rtl/bus_cycle_initiator.sv | 191 +++++++++++++++++++
 tb/tb_bus_cycle_initiator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_initiator.sv
// Minimum-mode 8088 bus master: turns one transfer request into a
// T1-T2-T3-(Tw)-T4 cycle on the multiplexed A/AD bus with registered strobes.
module bus_cycle_initiator #(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_IO,
  input  logic        REQ_WRITE,
  input  logic [19:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RDATA,
  input  logic        READY,
  output logic [11:0] A,
  output logic [7:0]  AD_OUT,
  output logic        AD_OE,
  input  logic [7:0]  AD_IN,
  output logic        ALE,
  output logic        IOM,
  output logic        RD_n,
  output logic        WR_n,
  output logic        DTR,
  output logic        DEN
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] T1   = 3'd1;
  localparam logic [2:0] T2   = 3'd2;
  localparam logic [2:0] T3   = 3'd3;
  localparam logic [2:0] TW   = 3'd4;
  localparam logic [2:0] T4   = 3'd5;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [11:0] addrHi_q, addrHi_d;
  logic [7:0]  adOut_q, adOut_d;
  logic        adOe_q, adOe_d;
  logic        ale_q, ale_d;
  logic        iom_q, iom_d;
  logic        rdN_q, rdN_d;
  logic        wrN_q, wrN_d;
  logic        dtr_q, dtr_d;
  logic        denN_q, denN_d;

  // Outputs are computed for the state being entered, so every pin is a flop.
  // DTR doubles as the captured write flag and IOM as the captured I/O flag.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    addrHi_d  = addrHi_q;
    adOut_d   = adOut_q;
    adOe_d    = adOe_q;
    ale_d     = ale_q;
    iom_d     = iom_q;
    rdN_d     = rdN_q;
    wrN_d     = wrN_q;
    dtr_d     = dtr_q;
    denN_d    = denN_q;

    case (state_q)
      IDLE: begin
        if (REQ) begin
          state_d   = T1;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          waitCnt_d = 8'd0;
          wdata_d   = REQ_WDATA;
          ale_d     = 1'b1;
          addrHi_d  = REQ_IO ? {4'h0, REQ_ADDR[15:8]} : REQ_ADDR[19:8];
          adOut_d   = REQ_ADDR[7:0];
          adOe_d    = 1'b1;
          iom_d     = REQ_IO;
          dtr_d     = REQ_WRITE;
        end
      end
      T1: begin
        state_d = T2;
        ale_d   = 1'b0;
        denN_d  = 1'b0;
        if (dtr_q) begin
          adOut_d = wdata_q;
          adOe_d  = 1'b1;
          wrN_d   = 1'b0;
        end else begin
          adOe_d  = 1'b0;
          rdN_d   = 1'b0;
        end
      end
      T2: begin
        state_d = T3;
      end
      T3, TW: begin
        if (READY || (waitCnt_q >= MAX_WAIT_C)) begin
          state_d = T4;
          done_d  = 1'b1;
          rdN_d   = 1'b1;
          wrN_d   = 1'b1;
          denN_d  = 1'b1;
          adOe_d  = 1'b0;
          if (!READY) begin
            err_d   = 1'b1;
            rdata_d = 8'h00;
          end else if (!dtr_q) begin
            rdata_d = AD_IN;
          end
        end else begin
          state_d   = TW;
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      T4: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        dtr_d   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      waitCnt_q <= 8'd0;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      addrHi_q  <= 12'h000;
      adOut_q   <= 8'h00;
      adOe_q    <= 1'b0;
      ale_q     <= 1'b0;
      iom_q     <= 1'b0;
      rdN_q     <= 1'b1;
      wrN_q     <= 1'b1;
      dtr_q     <= 1'b1;
      denN_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      addrHi_q  <= addrHi_d;
      adOut_q   <= adOut_d;
      adOe_q    <= adOe_d;
      ale_q     <= ale_d;
      iom_q     <= iom_d;
      rdN_q     <= rdN_d;
      wrN_q     <= wrN_d;
      dtr_q     <= dtr_d;
      denN_q    <= denN_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign ERR    = err_q;
  assign RDATA  = rdata_q;
  assign A      = addrHi_q;
  assign AD_OUT = adOut_q;
  assign AD_OE  = adOe_q;
  assign ALE    = ale_q;
  assign IOM    = iom_q;
  assign RD_n   = rdN_q;
  assign WR_n   = wrN_q;
  assign DTR    = dtr_q;
  assign DEN    = denN_q;

endmodule

// File: tb/tb_bus_cycle_initiator.sv
// Testbench for bus_cycle_initiator: per-scenario tasks with inline checks and
// a result scoreboard popped whenever the initiator signals DONE.
module tb_bus_cycle_initiator;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ = 1'b0;
  logic        REQ_IO = 1'b0;
  logic        REQ_WRITE = 1'b0;
  logic [19:0] REQ_ADDR = '0;
  logic [7:0]  REQ_WDATA = '0;
  logic        READY = 1'b1;
  logic [7:0]  AD_IN = '0;
  logic        BUSY, DONE, ERR, AD_OE, ALE, IOM, RD_n, WR_n, DTR, DEN;
  logic [7:0]  RDATA, AD_OUT;
  logic [11:0] A;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       err;
    logic       chkData;
    logic [7:0] rdata;
  } exp_t;

  exp_t sbQ[$];
  exp_t sbHead;

  always #5 CLK = ~CLK;

  bus_cycle_initiator #(.MAX_WAIT(3)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_IO(REQ_IO), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR), .RDATA(RDATA), .READY(READY), .A(A), .AD_OUT(AD_OUT),
    .AD_OE(AD_OE), .AD_IN(AD_IN), .ALE(ALE), .IOM(IOM), .RD_n(RD_n),
    .WR_n(WR_n), .DTR(DTR), .DEN(DEN)
  );

  // Strobe invariants every cycle, and result scoreboard on each DONE.
  always @(negedge CLK) begin
    if (!RESET) begin
      checks++;
      if ((!RD_n && !WR_n) || (AD_OE && !RD_n)) begin
        errors++;
        $display("[TB] FAIL strobe_inv RD_n=%b WR_n=%b AD_OE=%b", RD_n, WR_n, AD_OE);
      end
      if (DONE) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected_done got DONE=1 exp no pending transfer");
        end else begin
          sbHead = sbQ.pop_front();
          if (ERR !== sbHead.err || (sbHead.chkData && RDATA !== sbHead.rdata)) begin
            errors++;
            $display("[TB] FAIL sb_result got ERR=%b RDATA=%h exp ERR=%b RDATA=%h",
                     ERR, RDATA, sbHead.err, sbHead.rdata);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic io, input logic wr,
                               input logic [19:0] addr, input logic [7:0] wd);
    @(negedge CLK);
    REQ = 1'b1; REQ_IO = io; REQ_WRITE = wr; REQ_ADDR = addr; REQ_WDATA = wd;
    @(posedge CLK);
    #1 REQ = 1'b0;
    REQ_ADDR = 20'hFFFFF; REQ_WDATA = 8'hEE; REQ_IO = ~io; REQ_WRITE = ~wr;
  endtask

  task automatic test_reset_state;
    RESET = 1'b0;
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({BUSY, DONE, ERR, ALE, AD_OE, IOM} !== 6'b0) begin
      errors++; $display("[TB] FAIL rst_flags got=%b exp=000000", {BUSY, DONE, ERR, ALE, AD_OE, IOM});
    end
    checks++;
    if ({RD_n, WR_n, DTR, DEN} !== 4'hF) begin
      errors++; $display("[TB] FAIL rst_strobes got=%b exp=1111", {RD_n, WR_n, DTR, DEN});
    end
    checks++;
    if ({A, AD_OUT, RDATA} !== 28'h0) begin
      errors++; $display("[TB] FAIL rst_data got=%h exp=0", {A, AD_OUT, RDATA});
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_mem_read;
    sbQ.push_back('{err: 1'b0, chkData: 1'b1, rdata: 8'hA5});
    READY = 1'b1; AD_IN = 8'h11;
    applyStimulus(1'b0, 1'b0, 20'h80005, 8'h00);
    @(negedge CLK);
    checks++;
    if ({ALE, A, AD_OUT, AD_OE, IOM, DTR, BUSY, RD_n, DEN} !== {1'b1, 12'h800, 8'h05, 6'b100111}) begin
      errors++; $display("[TB] FAIL rd_t1 got=%h exp=%h",
        {ALE, A, AD_OUT, AD_OE, IOM, DTR, BUSY, RD_n, DEN}, {1'b1, 12'h800, 8'h05, 6'b100111});
    end
    @(negedge CLK);
    checks++;
    if ({ALE, AD_OE, RD_n, WR_n, DEN, DONE} !== 6'b000100) begin
      errors++; $display("[TB] FAIL rd_t2 got=%b exp=000100", {ALE, AD_OE, RD_n, WR_n, DEN, DONE});
    end
    @(negedge CLK);
    AD_IN = 8'hA5;
    checks++;
    if ({RD_n, DEN, DONE, A} !== {3'b000, 12'h800}) begin
      errors++; $display("[TB] FAIL rd_t3 got=%h exp=%h", {RD_n, DEN, DONE, A}, {3'b000, 12'h800});
    end
    @(negedge CLK);
    AD_IN = 8'h22;
    checks++;
    if ({DONE, BUSY, ERR, RDATA, IOM, RD_n, DEN, AD_OE} !== {3'b110, 8'hA5, 4'b0110}) begin
      errors++; $display("[TB] FAIL rd_t4 got=%h exp=%h",
        {DONE, BUSY, ERR, RDATA, IOM, RD_n, DEN, AD_OE}, {3'b110, 8'hA5, 4'b0110});
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, DTR, IOM, RDATA} !== {4'b0010, 8'hA5}) begin
      errors++; $display("[TB] FAIL rd_idle got=%h exp=%h", {BUSY, DONE, DTR, IOM, RDATA}, {4'b0010, 8'hA5});
    end
  endtask

  task automatic test_io_write;
    sbQ.push_back('{err: 1'b0, chkData: 1'b0, rdata: 8'h00});
    READY = 1'b1;
    applyStimulus(1'b1, 1'b1, 20'h5FF03, 8'h3C);
    @(negedge CLK);
    checks++;
    if ({ALE, A, AD_OUT, AD_OE, IOM, DTR, WR_n} !== {1'b1, 12'h0FF, 8'h03, 4'b1111}) begin
      errors++; $display("[TB] FAIL wr_t1 got=%h exp=%h",
        {ALE, A, AD_OUT, AD_OE, IOM, DTR, WR_n}, {1'b1, 12'h0FF, 8'h03, 4'b1111});
    end
    for (int c = 2; c <= 3; c++) begin
      @(negedge CLK);
      checks++;
      if ({AD_OUT, AD_OE, WR_n, RD_n, DEN, DTR, IOM, A} !== {8'h3C, 6'b101011, 12'h0FF}) begin
        errors++; $display("[TB] FAIL wr_t%0d got=%h exp=%h", c,
          {AD_OUT, AD_OE, WR_n, RD_n, DEN, DTR, IOM, A}, {8'h3C, 6'b101011, 12'h0FF});
      end
    end
    @(negedge CLK);
    checks++;
    if ({DONE, ERR, WR_n, DEN, AD_OE, RDATA} !== {5'b10110, 8'hA5}) begin
      errors++; $display("[TB] FAIL wr_t4 got=%h exp=%h", {DONE, ERR, WR_n, DEN, AD_OE, RDATA}, {5'b10110, 8'hA5});
    end
    @(negedge CLK);
    checks++;
    if ({BUSY, DONE, IOM, DTR} !== 4'b0011) begin
      errors++; $display("[TB] FAIL wr_idle got=%b exp=0011", {BUSY, DONE, IOM, DTR});
    end
  endtask

  task automatic test_wait_states;
    sbQ.push_back('{err: 1'b0, chkData: 1'b1, rdata: 8'h5A});
    READY = 1'b0; AD_IN = 8'h77;
    applyStimulus(1'b0, 1'b0, 20'h12345, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c >= 2) begin
        checks++;
        if ({RD_n, DEN, DONE, BUSY} !== 4'b0001) begin
          errors++; $display("[TB] FAIL ws_cycle%0d got=%b exp=0001", c, {RD_n, DEN, DONE, BUSY});
        end
      end
      if (c == 5) begin
        READY = 1'b1; AD_IN = 8'h5A;
      end
    end
    @(negedge CLK);
    AD_IN = 8'h77;
    checks++;
    if ({DONE, ERR, RD_n, RDATA} !== {3'b101, 8'h5A}) begin
      errors++; $display("[TB] FAIL ws_t4 got=%h exp=%h", {DONE, ERR, RD_n, RDATA}, {3'b101, 8'h5A});
    end
    @(negedge CLK);
  endtask

  task automatic test_timeout;
    sbQ.push_back('{err: 1'b1, chkData: 1'b1, rdata: 8'h00});
    READY = 1'b0; AD_IN = 8'h99;
    applyStimulus(1'b0, 1'b0, 20'h0F0F0, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (c >= 4) begin
        checks++;
        if ({RD_n, DONE, ERR} !== 3'b000) begin
          errors++; $display("[TB] FAIL to_tw%0d got=%b exp=000", c, {RD_n, DONE, ERR});
        end
      end
    end
    @(negedge CLK);
    checks++;
    if ({DONE, ERR, RDATA, RD_n, WR_n, DEN, AD_OE} !== {2'b11, 8'h00, 4'b1110}) begin
      errors++; $display("[TB] FAIL to_t4 got=%h exp=%h",
        {DONE, ERR, RDATA, RD_n, WR_n, DEN, AD_OE}, {2'b11, 8'h00, 4'b1110});
    end
    @(negedge CLK);
    READY = 1'b1;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b001) begin
      errors++; $display("[TB] FAIL to_idle got=%b exp=001", {BUSY, DONE, ERR});
    end
  endtask

  task automatic test_reset_midcycle;
    READY = 1'b1;
    applyStimulus(1'b0, 1'b1, 20'h01234, 8'h99);
    @(negedge CLK);
    checks++;
    if ({ALE, ERR, A} !== {2'b10, 12'h012}) begin
      errors++; $display("[TB] FAIL rm_t1_errclr got=%h exp=%h", {ALE, ERR, A}, {2'b10, 12'h012});
    end
    @(negedge CLK);
    checks++;
    if ({WR_n, DEN, AD_OE, AD_OUT} !== {3'b001, 8'h99}) begin
      errors++; $display("[TB] FAIL rm_t2 got=%h exp=%h", {WR_n, DEN, AD_OE, AD_OUT}, {3'b001, 8'h99});
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({WR_n, DEN, AD_OE, BUSY, A} !== {4'b1100, 12'h000}) begin
      errors++; $display("[TB] FAIL rm_async got=%h exp=%h", {WR_n, DEN, AD_OE, BUSY, A}, {4'b1100, 12'h000});
    end
    @(negedge CLK);
    RESET = 1'b0;
    sbQ.push_back('{err: 1'b0, chkData: 1'b1, rdata: 8'h42});
    AD_IN = 8'h42;
    applyStimulus(1'b0, 1'b0, 20'h0ABCD, 8'h00);
    @(negedge CLK);
    checks++;
    if ({ALE, A, AD_OUT} !== {1'b1, 12'h0AB, 8'hCD}) begin
      errors++; $display("[TB] FAIL rm_new_t1 got=%h exp=%h", {ALE, A, AD_OUT}, {1'b1, 12'h0AB, 8'hCD});
    end
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({DONE, ERR, RDATA} !== {2'b10, 8'h42}) begin
      errors++; $display("[TB] FAIL rm_new_t4 got=%h exp=%h", {DONE, ERR, RDATA}, {2'b10, 8'h42});
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    logic [19:0] accAddr;
    logic        expAle, expDone, expBusy;
    sbQ.push_back('{err: 1'b0, chkData: 1'b1, rdata: 8'hC1});
    sbQ.push_back('{err: 1'b0, chkData: 1'b1, rdata: 8'h2E});
    READY = 1'b1; AD_IN = 8'h00;
    @(negedge CLK);
    accAddr = 20'h11111;
    REQ = 1'b1; REQ_IO = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = accAddr;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      expAle  = (c == 1) || (c == 6);
      expDone = (c == 4) || (c == 9);
      expBusy = !((c == 5) || (c == 10));
      checks++;
      if ({ALE, DONE, BUSY} !== {expAle, expDone, expBusy}) begin
        errors++; $display("[TB] FAIL b2b_cycle%0d got=%b exp=%b", c, {ALE, DONE, BUSY}, {expAle, expDone, expBusy});
      end
      if (expAle) begin
        checks++;
        if ({A, AD_OUT} !== accAddr) begin
          errors++; $display("[TB] FAIL b2b_addr%0d got=%h exp=%h", c, {A, AD_OUT}, accAddr);
        end
      end
      REQ_ADDR = 20'($urandom);
      if (c == 5) accAddr = REQ_ADDR;
      if (c == 6) REQ = 1'b0;
      if (c == 3) AD_IN = 8'hC1;
      if (c == 8) AD_IN = 8'h2E;
      if (c == 4 || c == 9) AD_IN = 8'h00;
    end
  endtask

  initial begin
    test_reset_state();
    test_mem_read();
    test_io_write();
    test_wait_states();
    test_timeout();
    test_reset_midcycle();
    test_back_to_back();
    @(negedge CLK);
    checks++;
    if (sbQ.size() != 0) begin
      errors++; $display("[TB] FAIL sb_leftover got=%0d exp=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
